// File: rtl/ysyx_25060173_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem read at a time, holds the fetched word for the decoder.
// Request is combinational from state and pc, and the response is registered into a hold stage; redirects squash in-flight fetches.
module ysyx_25060173_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_stale_addr, w_stale_addr_nxt;
  logic        r_discard, w_discard_nxt;
  logic        r_inst_valid, w_inst_valid_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic [31:0] r_inst_pc, w_inst_pc_nxt;
  logic        r_inst_fault, w_inst_fault_nxt;
  logic [31:0] w_redirect_pc;
  logic        w_req_fire;

  assign w_redirect_pc  = redirect_pc & ~32'h3;
  assign imem_req_valid = (r_state == S_REQ) && !rst;
  // A request redirected before acceptance must keep its original address until the handshake.
  assign imem_req_addr  = r_discard ? r_stale_addr : r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_fault = r_inst_fault;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_stale_addr_nxt = r_stale_addr;
    w_discard_nxt    = r_discard;
    w_inst_valid_nxt = r_inst_valid;
    w_inst_nxt       = r_inst;
    w_inst_pc_nxt    = r_inst_pc;
    w_inst_fault_nxt = r_inst_fault;
    case (r_state)
      S_REQ: begin
        if (w_req_fire) begin
          w_state_nxt = S_WAIT;
        end
        if (redirect_valid) begin
          w_pc_nxt      = w_redirect_pc;
          w_discard_nxt = 1'b1;
          if (!w_req_fire && !r_discard) begin
            w_stale_addr_nxt = r_pc;
          end
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (r_discard || redirect_valid) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = S_REQ;
          end else begin
            w_inst_nxt       = imem_resp_err ? NOP : imem_resp_data;
            w_inst_pc_nxt    = r_pc;
            w_inst_fault_nxt = imem_resp_err;
            w_inst_valid_nxt = 1'b1;
            w_state_nxt      = S_HOLD;
          end
        end else if (redirect_valid) begin
          w_discard_nxt = 1'b1;
        end
        if (redirect_valid) begin
          w_pc_nxt = w_redirect_pc;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_pc_nxt         = w_redirect_pc;
          w_inst_valid_nxt = 1'b0;
          w_state_nxt      = S_REQ;
        end else if (inst_ready) begin
          w_pc_nxt         = r_pc + PC_STEP;
          w_inst_valid_nxt = 1'b0;
          w_state_nxt      = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_stale_addr <= RESET_PC;
      r_discard    <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= NOP;
      r_inst_pc    <= RESET_PC;
      r_inst_fault <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_stale_addr <= w_stale_addr_nxt;
      r_discard    <= w_discard_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
      r_inst_fault <= w_inst_fault_nxt;
    end
  end

  // Responses are only legal while a request is outstanding.
  a_resp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (r_state == S_WAIT));

endmodule

// File: tb/tb_ysyx_25060173_ifu.sv
// Bench for ysyx_25060173_ifu: directed scenarios plus a randomized run checked against
// an architectural PC-sequence model and a one-outstanding memory model.
module tb_ysyx_25060173_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int n_checks = 0;
  int n_pass   = 0;

  int          rdy_mode;
  int          max_delay;
  logic        mem_busy;
  int          mem_delay;
  logic [31:0] mem_addr;

  ysyx_25060173_ifu #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0093;
    if (a == 32'h8000_0004) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    if (a == 32'h8000_0008) return 1'b1;
    if (a[31:4] == 28'h800_0000) return 1'b0;
    return (a[9:2] % 8'd11) == 8'd7;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Memory model for one cycle: answers the outstanding read after its delay, then offers ready.
  task automatic drive_mem();
    logic rdy;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    imem_resp_err   = 1'b0;
    if (mem_busy) begin
      if (mem_delay == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_data(mem_addr);
        imem_resp_err   = mem_err(mem_addr);
        mem_busy        = 1'b0;
      end else begin
        mem_delay--;
      end
    end
    case (rdy_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      default: rdy = ($urandom_range(99) < 60);
    endcase
    imem_req_ready = rdy;
    if (imem_req_valid && rdy) begin
      n_checks++;
      if (mem_busy) $display("FAIL one_outstanding: request at %h while %h still pending", imem_req_addr, mem_addr);
      else n_pass++;
      mem_busy  = 1'b1;
      mem_addr  = imem_req_addr;
      mem_delay = $urandom_range(max_delay);
    end
  endtask

  task automatic run_until_inst(input int max, output int cyc);
    cyc = -1;
    for (int i = 0; i < max; i++) begin
      if (inst_valid) begin
        cyc = i;
        break;
      end
      drive_mem();
      tick();
    end
  endtask

  task automatic consume();
    inst_ready = 1'b1;
    drive_mem();
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({imem_req_valid, inst_valid, inst, inst_pc, inst_fault} !== {1'b0, 1'b0, NOP, RESET_PC, 1'b0})
      $display("FAIL reset_state: got v=%b iv=%b inst=%h pc=%h f=%b, need 0 0 %h %h 0",
               imem_req_valid, inst_valid, inst, inst_pc, inst_fault, NOP, RESET_PC);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC)
      $display("FAIL first_req: got v=%b addr=%h, need 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
    else n_pass++;
  endtask

  task automatic test_basic();
    int cyc;
    rdy_mode = 1; max_delay = 0;
    run_until_inst(10, cyc);
    n_checks++;
    if (cyc !== 2) $display("FAIL basic_latency: got %0d cycles, need 2", cyc);
    else n_pass++;
    n_checks++;
    if ({inst, inst_pc, inst_fault} !== {32'h0000_0093, 32'h8000_0000, 1'b0})
      $display("FAIL basic_inst: got %h @%h f=%b, need 00000093 @80000000 f=0", inst, inst_pc, inst_fault);
    else n_pass++;
    consume();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004 || inst_valid !== 1'b0)
      $display("FAIL basic_next_req: got v=%b addr=%h iv=%b, need 1 80000004 0", imem_req_valid, imem_req_addr, inst_valid);
    else n_pass++;
  endtask

  task automatic test_stall();
    int cyc;
    logic [31:0] h_inst, h_pc;
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) begin
      drive_mem();
      tick();
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004)
        $display("FAIL req_stall: cycle %0d got v=%b addr=%h, need 1 80000004", i, imem_req_valid, imem_req_addr);
      else n_pass++;
    end
    rdy_mode = 1;
    run_until_inst(10, cyc);
    n_checks++;
    if (cyc !== 2 || {inst, inst_pc} !== {32'h0010_0113, 32'h8000_0004})
      $display("FAIL stall_inst: got cyc=%0d %h @%h, need 2 00100113 @80000004", cyc, inst, inst_pc);
    else n_pass++;
    h_inst = inst; h_pc = inst_pc;
    for (int i = 0; i < 4; i++) begin
      drive_mem();
      tick();
      n_checks++;
      if (inst_valid !== 1'b1 || inst !== h_inst || inst_pc !== h_pc || imem_req_valid !== 1'b0)
        $display("FAIL hold_stall: cycle %0d got iv=%b %h @%h rv=%b, need 1 %h @%h 0",
                 i, inst_valid, inst, inst_pc, imem_req_valid, h_inst, h_pc);
      else n_pass++;
    end
    consume();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008)
      $display("FAIL stall_next_req: got v=%b addr=%h, need 1 80000008", imem_req_valid, imem_req_addr);
    else n_pass++;
  endtask

  task automatic test_fault();
    int cyc;
    run_until_inst(10, cyc);
    n_checks++;
    if ({inst_valid, inst_fault, inst, inst_pc} !== {1'b1, 1'b1, NOP, 32'h8000_0008})
      $display("FAIL fault_inst: got iv=%b f=%b %h @%h, need 1 1 %h @80000008", inst_valid, inst_fault, inst, inst_pc, NOP);
    else n_pass++;
    consume();
  endtask

  task automatic test_redirect_wait();
    int cyc;
    logic [31:0] e_inst;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0)
        $display("FAIL squash_wait: cycle %0d got iv=%b rv=%b, need 0 0", i, inst_valid, imem_req_valid);
      else n_pass++;
      tick();
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    n_checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100)
      $display("FAIL squash_refetch: got iv=%b rv=%b addr=%h, need 0 1 80000100", inst_valid, imem_req_valid, imem_req_addr);
    else n_pass++;
    run_until_inst(10, cyc);
    e_inst = mem_err(32'h8000_0100) ? NOP : mem_data(32'h8000_0100);
    n_checks++;
    if (cyc !== 2 || inst === 32'hDEAD_BEEF || {inst, inst_pc} !== {e_inst, 32'h8000_0100})
      $display("FAIL squash_inst: got cyc=%0d %h @%h, need 2 %h @80000100", cyc, inst, inst_pc, e_inst);
    else n_pass++;
  endtask

  task automatic test_redirect_hold();
    int cyc;
    logic [31:0] e_inst;
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0203;
    drive_mem();
    tick();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    n_checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200)
      $display("FAIL redirect_hold: got iv=%b rv=%b addr=%h, need 0 1 80000200", inst_valid, imem_req_valid, imem_req_addr);
    else n_pass++;
    run_until_inst(10, cyc);
    e_inst = mem_err(32'h8000_0200) ? NOP : mem_data(32'h8000_0200);
    n_checks++;
    if ({inst, inst_pc, inst_fault} !== {e_inst, 32'h8000_0200, mem_err(32'h8000_0200)})
      $display("FAIL redirect_hold_inst: got %h @%h f=%b, need %h @80000200", inst, inst_pc, inst_fault, e_inst);
    else n_pass++;
    consume();
  endtask

  task automatic test_wrap_reset();
    int cyc;
    rdy_mode       = 0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    drive_mem();
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0204)
      $display("FAIL redirect_req_hold_addr: got v=%b addr=%h, need 1 80000204", imem_req_valid, imem_req_addr);
    else n_pass++;
    rdy_mode = 1;
    run_until_inst(20, cyc);
    n_checks++;
    if (cyc < 0 || inst_pc !== 32'hFFFF_FFFC || inst !== mem_data(32'hFFFF_FFFC))
      $display("FAIL wrap_inst: got cyc=%0d %h @%h, need %h @fffffffc", cyc, inst, inst_pc, mem_data(32'hFFFF_FFFC));
    else n_pass++;
    consume();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000)
      $display("FAIL wrap_addr: got v=%b addr=%h, need 1 00000000", imem_req_valid, imem_req_addr);
    else n_pass++;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({imem_req_valid, inst_valid, inst, inst_pc, inst_fault} !== {1'b0, 1'b0, NOP, RESET_PC, 1'b0})
      $display("FAIL async_reset: got v=%b iv=%b %h @%h f=%b, need 0 0 %h @%h 0",
               imem_req_valid, inst_valid, inst, inst_pc, inst_fault, NOP, RESET_PC);
    else n_pass++;
    mem_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC)
      $display("FAIL post_reset_req: got v=%b addr=%h, need 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
    else n_pass++;
  endtask

  // Architectural model: consumed PCs follow +4 except that a redirect sets the next PC.
  task automatic test_random();
    logic [31:0] exp_pc, prev_addr, prev_inst, prev_pc, tgt, exp_inst;
    logic        prev_stall, prev_hold, prev_fault, redir, exp_fault;
    int          consumed;
    exp_pc = RESET_PC; consumed = 0;
    prev_stall = 1'b0; prev_hold = 1'b0; prev_addr = '0;
    prev_inst = '0; prev_pc = '0; prev_fault = 1'b0;
    rdy_mode = 2; max_delay = 3;
    for (int c = 0; c < 3000; c++) begin
      if (prev_stall) begin
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr)
          $display("FAIL rnd_req_stable: cycle %0d got v=%b addr=%h, need 1 %h", c, imem_req_valid, imem_req_addr, prev_addr);
        else n_pass++;
      end
      if (prev_hold) begin
        n_checks++;
        if ({inst_valid, inst, inst_pc, inst_fault} !== {1'b1, prev_inst, prev_pc, prev_fault})
          $display("FAIL rnd_hold_stable: cycle %0d got iv=%b %h @%h, need 1 %h @%h", c, inst_valid, inst, inst_pc, prev_inst, prev_pc);
        else n_pass++;
      end
      drive_mem();
      inst_ready = ($urandom_range(99) < 70);
      redir      = ($urandom_range(99) < 5);
      tgt        = $urandom;
      if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | {28'h0, tgt[3:0]};
      redirect_valid = redir;
      redirect_pc    = tgt;
      if (redir) begin
        exp_pc = tgt & ~32'h3;
      end else if (inst_valid && inst_ready) begin
        exp_fault = mem_err(exp_pc);
        exp_inst  = exp_fault ? NOP : mem_data(exp_pc);
        n_checks++;
        if ({inst, inst_pc, inst_fault} !== {exp_inst, exp_pc, exp_fault})
          $display("FAIL rnd_inst: cycle %0d got %h @%h f=%b, need %h @%h f=%b",
                   c, inst, inst_pc, inst_fault, exp_inst, exp_pc, exp_fault);
        else n_pass++;
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      prev_stall = imem_req_valid && !imem_req_ready;
      prev_addr  = imem_req_addr;
      prev_hold  = inst_valid && !inst_ready && !redir;
      prev_inst  = inst; prev_pc = inst_pc; prev_fault = inst_fault;
      tick();
    end
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    n_checks++;
    if (consumed < 100) $display("FAIL rnd_progress: consumed %0d, need at least 100", consumed);
    else n_pass++;
  endtask

  initial begin
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    imem_resp_err   = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    inst_ready      = 1'b0;
    rdy_mode        = 1;
    max_delay       = 0;
    mem_busy        = 1'b0;
    mem_delay       = 0;
    mem_addr        = 32'h0;
    test_reset();
    test_basic();
    test_stall();
    test_fault();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
